// File: rtl/sopc_mem_arbiter_pkg.sv
// sopc_mem_arbiter_pkg: shared state/grant encodings and memory-port control constants
package sopc_mem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} arb_state_e;
  typedef enum logic {GRANT_IF = 1'b0, GRANT_DM = 1'b1} grant_e;
  localparam logic CHIP_ENABLE   = 1'b1;
  localparam logic CHIP_DISABLE  = 1'b0;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam int DEFAULT_WAIT_CYCLES = 2;
endpackage

// File: rtl/arb_wait_timer.sv
// arb_wait_timer: loadable down-counter that flags the last cycle of a memory access
module arb_wait_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);
  logic [CNT_W-1:0] cnt_d, cnt_q;
  always_comb cnt_d = load ? load_val : (dec && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign zero = cnt_q == '0;
endmodule

// File: rtl/sopc_mem_arbiter.sv
// sopc_mem_arbiter: shares one SOPC memory port between instruction fetch and data access,
// data side has fixed priority; each access is IDLE -> ACCESS (WAIT_CYCLES) -> RESP.
module sopc_mem_arbiter
  import sopc_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
  parameter int CNT_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [3:0]        dm_sel,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              stallreq,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [3:0]        mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  if (WAIT_CYCLES < 1 || WAIT_CYCLES >= (1 << CNT_W)) begin : g_bad_wait
    $error("sopc_mem_arbiter: WAIT_CYCLES must be 1..2**CNT_W-1");
  end
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYCLES - 1);
  arb_state_e        state_d, state_q;
  grant_e            grant_d, grant_q;
  logic              mem_ce_d, mem_ce_q, mem_we_d, mem_we_q;
  logic [3:0]        mem_sel_d, mem_sel_q;
  logic [ADDR_W-1:0] mem_addr_d, mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_d, mem_wdata_q;
  logic [DATA_W-1:0] if_rdata_d, if_rdata_q, dm_rdata_d, dm_rdata_q;
  logic              if_ack_d, if_ack_q, dm_ack_d, dm_ack_q;
  logic              load, dec, zero;
  arb_wait_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .dec      (dec),
    .load_val (LOAD_VAL),
    .zero     (zero)
  );
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    mem_ce_d    = mem_ce_q;
    mem_we_d    = mem_we_q;
    mem_sel_d   = mem_sel_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    load        = 1'b0;
    dec         = 1'b0;
    case (state_q)
      IDLE: if (dm_req || if_req) begin
        state_d     = ACCESS;
        grant_d     = dm_req ? GRANT_DM : GRANT_IF;
        load        = 1'b1;
        mem_ce_d    = CHIP_ENABLE;
        mem_we_d    = dm_req ? dm_we : WRITE_DISABLE;
        mem_sel_d   = dm_req ? dm_sel : 4'hF;
        mem_addr_d  = dm_req ? dm_addr : if_addr;
        mem_wdata_d = dm_req ? dm_wdata : mem_wdata_q;
      end
      ACCESS: begin
        dec = 1'b1;
        // mem_rdata is only valid in the final access cycle
        if (zero) begin
          state_d    = RESP;
          mem_ce_d   = CHIP_DISABLE;
          mem_we_d   = WRITE_DISABLE;
          dm_ack_d   = grant_q == GRANT_DM;
          if_ack_d   = grant_q == GRANT_IF;
          dm_rdata_d = (grant_q == GRANT_DM && !mem_we_q) ? mem_rdata : dm_rdata_q;
          if_rdata_d = (grant_q == GRANT_IF) ? mem_rdata : if_rdata_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q     <= IDLE;
      grant_q     <= GRANT_IF;
      mem_ce_q    <= CHIP_DISABLE;
      mem_we_q    <= WRITE_DISABLE;
      mem_sel_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      mem_ce_q    <= mem_ce_d;
      mem_we_q    <= mem_we_d;
      mem_sel_q   <= mem_sel_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
    end
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign mem_ce    = mem_ce_q;
  assign mem_we    = mem_we_q;
  assign mem_sel   = mem_sel_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  // held low in reset so every output is quiet regardless of requests
  assign stallreq  = rst & ((if_req & ~if_ack_q) | (dm_req & ~dm_ack_q));
endmodule

// File: tb/tb_sopc_mem_arbiter.sv
// tb_sopc_mem_arbiter: directed scenarios plus randomized transactions against a
// transaction-level timing/memory model of the arbiter.
module tb_sopc_mem_arbiter;
  localparam int W = 2;
  logic        clk = 1'b0, rst = 1'b0;
  logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
  logic [3:0]  dm_sel = '0;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_ack, dm_ack, stallreq, mem_ce, mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] dev_mem [16] = '{default: 32'h0};
  logic        pl_en = 1'b0;
  logic [3:0]  pl_idx = '0;
  logic [31:0] pl_val = '0;
  int cmp_n = 0, fail_n = 0;

  sopc_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(W), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_sel(dm_sel), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .stallreq(stallreq), .mem_ce(mem_ce), .mem_we(mem_we), .mem_sel(mem_sel),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #10 clk = ~clk;

  // behavioural single-port RAM: 16 words, byte-lane writes
  assign mem_rdata = dev_mem[mem_addr[5:2]];
  always @(posedge clk) begin
    if (pl_en) dev_mem[pl_idx] <= pl_val;
    else if (mem_ce && mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_sel[b]) dev_mem[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic preload(input int idx, input logic [31:0] v);
    pl_en = 1'b1; pl_idx = 4'(idx); pl_val = v;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    repeat (9) begin
      @(negedge clk);
      if_req = 1'($urandom); dm_req = 1'($urandom); dm_we = 1'($urandom);
      if_addr = $urandom; dm_addr = $urandom; dm_wdata = $urandom; dm_sel = 4'($urandom);
      #1 cmp_n++;
      if ({if_rdata, dm_rdata, mem_addr, mem_wdata, mem_sel, if_ack, dm_ack, stallreq, mem_ce, mem_we} !== '0) begin
        fail_n++; $display("FAIL reset_outputs t=%0t ce=%b stall=%b acks=%b%b got nonzero exp all 0", $time, mem_ce, stallreq, if_ack, dm_ack);
      end
    end
    #14;
    dm_req = 1'b0; if_req = 1'b1; if_addr = 32'h0;
    rst = 1'b1;
    @(negedge clk);
    cmp_n++; if (mem_ce !== 1'b0) begin fail_n++; $display("FAIL reset_release_c0 mem_ce=%b exp 0", mem_ce); end
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      cmp_n++; if (mem_ce !== (c <= 2)) begin fail_n++; $display("FAIL reset_first_access c=%0d mem_ce=%b exp %b", c, mem_ce, c <= 2); end
      cmp_n++; if (if_ack !== (c == 3)) begin fail_n++; $display("FAIL reset_first_ack c=%0d if_ack=%b exp %b", c, if_ack, c == 3); end
      if (c == 3) if_req = 1'b0;
    end
  endtask

  task automatic test_if_read();
    preload(1, 32'h3401_1100);
    if_req = 1'b1; if_addr = 32'h0000_0004;
    #1 cmp_n++; if (stallreq !== 1'b1) begin fail_n++; $display("FAIL if_read_stall_c0 got=%b exp 1", stallreq); end
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      cmp_n++; if (mem_ce !== (c <= 2)) begin fail_n++; $display("FAIL if_read_ce c=%0d got=%b exp %b", c, mem_ce, c <= 2); end
      if (c <= 2) begin
        cmp_n++;
        if ({mem_addr, mem_sel, mem_we} !== {32'h4, 4'hF, 1'b0}) begin
          fail_n++; $display("FAIL if_read_port c=%0d addr=%h sel=%h we=%b exp 4/F/0", c, mem_addr, mem_sel, mem_we);
        end
      end
      cmp_n++; if (if_ack !== (c == 3)) begin fail_n++; $display("FAIL if_read_ack c=%0d got=%b exp %b", c, if_ack, c == 3); end
      if (c == 3) begin
        cmp_n++; if (if_rdata !== 32'h3401_1100) begin fail_n++; $display("FAIL if_read_rdata got=%h exp 34011100", if_rdata); end
        if_req = 1'b0;
        #1 cmp_n++; if (stallreq !== 1'b0) begin fail_n++; $display("FAIL if_read_stall_drop got=%b exp 0", stallreq); end
      end
    end
  endtask

  task automatic test_simultaneous();
    logic exp_ce;
    if_req = 1'b1; if_addr = 32'h8;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF; dm_sel = 4'b0011;
    #1 cmp_n++; if (stallreq !== 1'b1) begin fail_n++; $display("FAIL simul_stall c=0 got=%b exp 1", stallreq); end
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      exp_ce = (c >= 1 && c <= 2) || (c >= 5 && c <= 6);
      cmp_n++; if (mem_ce !== exp_ce) begin fail_n++; $display("FAIL simul_ce c=%0d got=%b exp %b", c, mem_ce, exp_ce); end
      if (c <= 2) begin
        cmp_n++;
        if ({mem_addr, mem_sel, mem_we, mem_wdata} !== {32'h100, 4'b0011, 1'b1, 32'hDEAD_BEEF}) begin
          fail_n++; $display("FAIL simul_dm_port c=%0d addr=%h sel=%b we=%b wd=%h", c, mem_addr, mem_sel, mem_we, mem_wdata);
        end
      end
      if (c == 5 || c == 6) begin
        cmp_n++;
        if ({mem_addr, mem_sel, mem_we} !== {32'h8, 4'hF, 1'b0}) begin
          fail_n++; $display("FAIL simul_if_port c=%0d addr=%h sel=%h we=%b exp 8/F/0", c, mem_addr, mem_sel, mem_we);
        end
      end
      cmp_n++; if ({dm_ack, if_ack} !== {c == 3, c == 7}) begin fail_n++; $display("FAIL simul_acks c=%0d dm=%b if=%b exp %b %b", c, dm_ack, if_ack, c == 3, c == 7); end
      cmp_n++; if (stallreq !== (c < 7)) begin fail_n++; $display("FAIL simul_stall c=%0d got=%b exp %b", c, stallreq, c < 7); end
      if (c == 3) dm_req = 1'b0;
      if (c == 7) if_req = 1'b0;
    end
  endtask

  task automatic test_dm_read_write();
    preload(2, 32'hCAFE_0001);
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h8; dm_sel = 4'hF;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c <= 2) begin
        cmp_n++; if ({mem_ce, mem_we} !== 2'b10) begin fail_n++; $display("FAIL dm_read_port c=%0d ce=%b we=%b exp 1 0", c, mem_ce, mem_we); end
      end else begin
        cmp_n++; if ({dm_ack, dm_rdata} !== {1'b1, 32'hCAFE_0001}) begin fail_n++; $display("FAIL dm_read_resp ack=%b rdata=%h exp 1 cafe0001", dm_ack, dm_rdata); end
        dm_req = 1'b0;
      end
    end
    @(negedge clk);
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h20; dm_wdata = 32'h1234_5678; dm_sel = 4'b1100;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c <= 2) begin
        cmp_n++;
        if ({mem_ce, mem_we, mem_sel, mem_wdata} !== {1'b1, 1'b1, 4'b1100, 32'h1234_5678}) begin
          fail_n++; $display("FAIL dm_write_port c=%0d ce=%b we=%b sel=%b wd=%h", c, mem_ce, mem_we, mem_sel, mem_wdata);
        end
      end
      if (c == 3) begin
        cmp_n++; if ({mem_ce, mem_sel, mem_addr} !== {1'b0, 4'b1100, 32'h20}) begin fail_n++; $display("FAIL dm_write_hold ce=%b sel=%b addr=%h exp 0 1100 20", mem_ce, mem_sel, mem_addr); end
        dm_req = 1'b0;
      end
      cmp_n++; if (dm_ack !== (c == 3)) begin fail_n++; $display("FAIL dm_write_ack c=%0d got=%b exp %b", c, dm_ack, c == 3); end
      cmp_n++; if (dm_rdata !== 32'hCAFE_0001) begin fail_n++; $display("FAIL dm_write_rdata c=%0d got=%h exp cafe0001", c, dm_rdata); end
    end
  endtask

  task automatic test_withdraw();
    preload(3, 32'hA5A5_5A5A);
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'hC; dm_sel = 4'hF;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) dm_req = 1'b0;
      cmp_n++; if (mem_ce !== (c <= 2)) begin fail_n++; $display("FAIL withdraw_ce c=%0d got=%b exp %b", c, mem_ce, c <= 2); end
      cmp_n++; if (dm_ack !== (c == 3)) begin fail_n++; $display("FAIL withdraw_ack c=%0d got=%b exp %b", c, dm_ack, c == 3); end
      if (c == 3) begin
        cmp_n++; if (dm_rdata !== 32'hA5A5_5A5A) begin fail_n++; $display("FAIL withdraw_rdata got=%h exp a5a55a5a", dm_rdata); end
      end
    end
    if_req = 1'b1; if_addr = 32'h4;
    #3 if_req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      cmp_n++; if ({mem_ce, if_ack} !== 2'b00) begin fail_n++; $display("FAIL pregrant_withdraw ce=%b ack=%b exp 0 0", mem_ce, if_ack); end
    end
  endtask

  task automatic test_mid_reset();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'hC; dm_sel = 4'hF;
    @(negedge clk);
    cmp_n++; if (mem_ce !== 1'b1) begin fail_n++; $display("FAIL midreset_pre ce=%b exp 1", mem_ce); end
    rst = 1'b0;
    #1 cmp_n++; if (mem_ce !== 1'b0) begin fail_n++; $display("FAIL midreset_async ce=%b exp 0", mem_ce); end
    dm_req = 1'b0;
    @(negedge clk);
    #5 rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      cmp_n++; if ({mem_ce, if_ack, dm_ack} !== 3'b000) begin fail_n++; $display("FAIL midreset_quiet c=%0d ce=%b if_ack=%b dm_ack=%b exp 0", c, mem_ce, if_ack, dm_ack); end
    end
    if_req = 1'b1; if_addr = 32'h4;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      cmp_n++; if ({mem_ce, if_ack} !== {c <= 2, c == 3}) begin fail_n++; $display("FAIL midreset_idle c=%0d ce=%b ack=%b exp %b %b", c, mem_ce, if_ack, c <= 2, c == 3); end
    end
    if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] ref_mem [16];
    logic [31:0] exp_if_rd, exp_dm_rd, ia, da, wd, dm_exp, if_exp;
    logic [3:0]  dsel;
    logic        has_if, has_dm, dwe, wdr, in_dm, in_if, ack_dm_e, ack_if_e, exp_stall;
    int          kind, s_if, last;
    @(negedge clk);
    rst = 1'b0;
    #5 rst = 1'b1;
    exp_if_rd = '0; exp_dm_rd = '0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin ref_mem[i] = $urandom; preload(i, ref_mem[i]); end
    for (int t = 0; t < 40; t++) begin
      kind = int'($urandom_range(0, 2));
      has_if = kind != 1; has_dm = kind != 0;
      ia = $urandom & ~32'h3; da = $urandom & ~32'h3; wd = $urandom;
      dsel = 4'($urandom); dwe = 1'($urandom); wdr = has_dm && $urandom_range(0, 3) == 0;
      dm_exp = '0; if_exp = '0;
      // DM is always served first, so its write is visible to a later IF read
      if (has_dm) begin
        if (dwe) begin
          for (int b = 0; b < 4; b++) if (dsel[b]) ref_mem[da[5:2]][8*b +: 8] = wd[8*b +: 8];
        end else dm_exp = ref_mem[da[5:2]];
      end
      s_if = has_dm ? W + 2 : 0;
      if (has_if) if_exp = ref_mem[ia[5:2]];
      last = (has_if ? s_if : 0) + W + 1;
      @(negedge clk);
      if_req = has_if; if_addr = ia;
      dm_req = has_dm; dm_addr = da; dm_we = dwe; dm_sel = dsel; dm_wdata = wd;
      for (int c = 1; c <= last + 1; c++) begin
        @(negedge clk);
        in_dm = has_dm && c >= 1 && c <= W;
        in_if = has_if && c >= s_if + 1 && c <= s_if + W;
        ack_dm_e = has_dm && c == W + 1;
        ack_if_e = has_if && c == s_if + W + 1;
        if (ack_dm_e && !dwe) exp_dm_rd = dm_exp;
        if (ack_if_e) exp_if_rd = if_exp;
        cmp_n++; if (mem_ce !== (in_dm | in_if)) begin fail_n++; $display("FAIL rnd_ce t=%0d c=%0d got=%b exp %b", t, c, mem_ce, in_dm | in_if); end
        if (in_dm) begin
          cmp_n++;
          if ({mem_addr, mem_we, mem_sel} !== {da, dwe, dsel} || (dwe && mem_wdata !== wd)) begin
            fail_n++; $display("FAIL rnd_dm_port t=%0d c=%0d addr=%h we=%b sel=%b wd=%h exp %h %b %b %h", t, c, mem_addr, mem_we, mem_sel, mem_wdata, da, dwe, dsel, wd);
          end
        end
        if (in_if) begin
          cmp_n++;
          if ({mem_addr, mem_we, mem_sel} !== {ia, 1'b0, 4'hF}) begin
            fail_n++; $display("FAIL rnd_if_port t=%0d c=%0d addr=%h we=%b sel=%b exp %h 0 1111", t, c, mem_addr, mem_we, mem_sel, ia);
          end
        end
        cmp_n++; if ({if_ack, dm_ack} !== {ack_if_e, ack_dm_e}) begin fail_n++; $display("FAIL rnd_acks t=%0d c=%0d if=%b dm=%b exp %b %b", t, c, if_ack, dm_ack, ack_if_e, ack_dm_e); end
        cmp_n++; if ({if_rdata, dm_rdata} !== {exp_if_rd, exp_dm_rd}) begin fail_n++; $display("FAIL rnd_rdata t=%0d c=%0d if=%h dm=%h exp %h %h", t, c, if_rdata, dm_rdata, exp_if_rd, exp_dm_rd); end
        exp_stall = (if_req & ~ack_if_e) | (dm_req & ~ack_dm_e);
        cmp_n++; if (stallreq !== exp_stall) begin fail_n++; $display("FAIL rnd_stall t=%0d c=%0d got=%b exp %b", t, c, stallreq, exp_stall); end
        if (ack_dm_e || (wdr && c == 1)) dm_req = 1'b0;
        if (ack_if_e) if_req = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_simultaneous();
    test_dm_read_write();
    test_withdraw();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
    $finish;
  end
endmodule
